jam_dispatch: RTL and testbench
===============================

JAM_DISPATCH -- requirements
Module: jam_dispatch

Interface
REQ-001 SHALL have parameter NUM_WORKERS, default 2, number of attached permutation-search workers (range 1..8).
REQ-002 SHALL have parameter NUM_PREFIX, default 8, number of sub-searches; prefix k fixes worker 0 to job k.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a full search.
REQ-006 SHALL have port wk_start  output  NUM_WORKERS  per-worker one-cycle launch pulse.
REQ-007 SHALL have port wk_prefix  output  3*NUM_WORKERS  per-worker prefix job, 3 bits per worker, worker i at bits [3i+2:3i].
REQ-008 SHALL have port wk_done  input  NUM_WORKERS  per-worker result-ready level, held until acked.
REQ-009 SHALL have port wk_min  input  10*NUM_WORKERS  per-worker minimum cost.
REQ-010 SHALL have port wk_count  input  4*NUM_WORKERS  per-worker tie count.
REQ-011 SHALL have port wk_ack  output  NUM_WORKERS  per-worker one-cycle result-consumed pulse.
REQ-012 SHALL have port MinCost  output  10  global minimum cost.
REQ-013 SHALL have port MatchCount  output  4  global count of assignments at MinCost.
REQ-014 SHALL have port Valid  output  1  one-cycle pulse when MinCost and MatchCount are final.
REQ-015 SHALL have port busy  output  1  high from the cycle after start until the Valid cycle, inclusive.
REQ-016 SHALL have port cycle_cnt  output  16  search duration in cycles (see Configuration).

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; start in IDLE -> RUN; all prefixes merged -> DONE; DONE -> IDLE after 1 cycle.
REQ-018 SHALL ignore start when not in IDLE.
REQ-019 SHALL, on accepted start, load MinCost=10'h3FF, MatchCount=0, prefix counter=0, and clear all worker-busy flags.
REQ-020 SHALL in RUN, each cycle, issue wk_start to the lowest-index non-busy worker while prefix counter < NUM_PREFIX; at most one launch per cycle.
REQ-021 SHALL drive that worker's wk_prefix with the prefix counter value and hold it stable until that worker's wk_ack.
REQ-022 SHALL increment the prefix counter on every launch and set the worker's busy flag.
REQ-023 SHALL, each cycle, ack exactly one busy worker with wk_done high, lowest index first; other done workers wait.
REQ-024 SHALL merge the acked worker: wk_min < MinCost -> MinCost=wk_min, MatchCount=wk_count; wk_min == MinCost -> MatchCount = MatchCount + wk_count, saturating at 15; greater -> no change.
REQ-025 SHALL clear the worker's busy flag on ack; the worker is relaunchable no earlier than the following cycle.
REQ-026 SHALL ignore wk_done from non-busy workers.
REQ-027 SHALL enter DONE once NUM_PREFIX prefixes are launched and all are acked; Valid is high for the DONE cycle only.
REQ-028 SHALL hold MinCost and MatchCount after Valid until the next accepted start.
REQ-029 SHALL allow a launch and an ack to occur in the same cycle, including to different workers.

Reset
REQ-030 SHALL on RST_N low, asynchronously: FSM=IDLE, MinCost=10'h3FF, MatchCount=0, Valid=0, busy=0, wk_start=0, wk_ack=0, wk_prefix=0, cycle_cnt=0, busy flags cleared.
REQ-031 SHALL abandon any in-flight search on reset; results from workers arriving after reset release are ignored.

Configuration
REQ-032 SHALL with JAM_DISPATCH_STATS_EN defined: cycle_cnt clears on accepted start, increments every RUN cycle, saturates at 16'hFFFF, and holds through DONE/IDLE.
REQ-033 SHALL without JAM_DISPATCH_STATS_EN: drive cycle_cnt constantly 0 and instantiate no counter logic.

Structure
REQ-034 SHALL place JOB_W=3, COST_W=10, CNT_W=4, COST_INIT=10'h3FF and the FSM state enum in shared package jam_pkg.
REQ-035 SHALL implement lowest-index selection (used for both launch and ack) in sub-module jam_lsb_pick, instantiated twice.

Verification
REQ-036 SHALL cover: NUM_WORKERS=2, workers done after 10 cycles with wk_min=k+100 for prefix k, count 1 -> MinCost=100, MatchCount=1, one Valid pulse.
REQ-037 SHALL cover: all 8 prefixes return wk_min=50, count 3 -> MatchCount saturates at 15, MinCost=50.
REQ-038 SHALL cover: both workers raise wk_done in the same cycle -> worker 0 acked first, worker 1 acked the next cycle, wk_prefix[5:3] stable until worker 1's ack.
REQ-039 SHALL cover: start pulsed during RUN -> ignored, search result unchanged, busy stays high.
REQ-040 SHALL cover: RST_N low mid-RUN after 3 launches -> outputs at reset values immediately; next start completes a fresh 8-prefix search.
REQ-041 SHALL cover: with JAM_DISPATCH_STATS_EN defined and workers of fixed 10-cycle latency -> cycle_cnt equals the measured start-to-Valid RUN cycle count; without the macro -> cycle_cnt=0 throughout.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared widths, reset constants and FSM state encoding for the jam_dispatch search dispatcher.
package jam_pkg;

    localparam int JOB_W  = 3;
    localparam int COST_W = 10;
    localparam int CNT_W  = 4;

    localparam logic [COST_W-1:0] COST_INIT = 10'h3FF;
    localparam logic [CNT_W-1:0]  CNT_MAX   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/jam_lsb_pick.sv
// Lowest-index one-hot picker, shared by the launch and the ack arbitration.
module jam_lsb_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);

    // Two's-complement trick isolates the lowest set bit.
    assign gnt = req & (~req + N'(1));
    assign any = |req;

endmodule

// File: rtl/jam_dispatch.sv
// Farms NUM_PREFIX sub-searches out to NUM_WORKERS workers and merges their min/tie results.
// Optional JAM_DISPATCH_STATS_EN adds a saturating RUN-cycle counter on cycle_cnt.
module jam_dispatch
    import jam_pkg::*;
#(
    parameter int NUM_WORKERS = 2,
    parameter int NUM_PREFIX  = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          start,
    output logic [NUM_WORKERS-1:0]        wk_start,
    output logic [JOB_W*NUM_WORKERS-1:0]  wk_prefix,
    input  logic [NUM_WORKERS-1:0]        wk_done,
    input  logic [COST_W*NUM_WORKERS-1:0] wk_min,
    input  logic [CNT_W*NUM_WORKERS-1:0]  wk_count,
    output logic [NUM_WORKERS-1:0]        wk_ack,
    output logic [COST_W-1:0]             MinCost,
    output logic [CNT_W-1:0]              MatchCount,
    output logic                          Valid,
    output logic                          busy,
    output logic [15:0]                   cycle_cnt
);

    localparam int PFX_W = $clog2(NUM_PREFIX + 1);
    localparam logic [PFX_W-1:0] PFX_END = PFX_W'(NUM_PREFIX);

    state_t                 state;
    logic [NUM_WORKERS-1:0] wk_busy;
    logic [NUM_WORKERS-1:0] launch_req, launch_gnt, ack_req, ack_gnt;
    logic                   launch_any, ack_any;
    logic [PFX_W-1:0]       pfx_cnt;
    logic                   pfx_left, run_done;
    logic [COST_W-1:0]      sel_min;
    logic [CNT_W-1:0]       sel_cnt;
    logic [CNT_W:0]         cnt_sum;
    logic [CNT_W-1:0]       cnt_sat;

    assign pfx_left   = (pfx_cnt < PFX_END);
    assign launch_req = (state == ST_RUN && pfx_left) ? ~wk_busy : '0;
    // Done levels from idle workers are stale and never reach the arbiter.
    assign ack_req    = (state == ST_RUN) ? (wk_busy & wk_done) : '0;
    assign run_done   = (state == ST_RUN) && !pfx_left && (wk_busy == '0);

    jam_lsb_pick #(.N(NUM_WORKERS)) u_launch_pick (
        .req (launch_req),
        .gnt (launch_gnt),
        .any (launch_any)
    );

    jam_lsb_pick #(.N(NUM_WORKERS)) u_ack_pick (
        .req (ack_req),
        .gnt (ack_gnt),
        .any (ack_any)
    );

    always_comb begin
        sel_min = '0;
        sel_cnt = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (ack_gnt[i]) begin
                sel_min = sel_min | wk_min[COST_W*i +: COST_W];
                sel_cnt = sel_cnt | wk_count[CNT_W*i +: CNT_W];
            end
        end
        cnt_sum = {1'b0, MatchCount} + {1'b0, sel_cnt};
        cnt_sat = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            MinCost    <= COST_INIT;
            MatchCount <= '0;
            Valid      <= 1'b0;
            busy       <= 1'b0;
            wk_start   <= '0;
            wk_ack     <= '0;
            wk_prefix  <= '0;
            wk_busy    <= '0;
            pfx_cnt    <= '0;
        end else begin
            wk_start <= '0;
            wk_ack   <= '0;
            Valid    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                        MinCost    <= COST_INIT;
                        MatchCount <= '0;
                        pfx_cnt    <= '0;
                        wk_busy    <= '0;
                    end
                end
                ST_RUN: begin
                    wk_start <= launch_gnt;
                    wk_ack   <= ack_gnt;
                    wk_busy  <= (wk_busy | launch_gnt) & ~ack_gnt;
                    if (launch_any) begin
                        pfx_cnt <= pfx_cnt + PFX_W'(1);
                        for (int i = 0; i < NUM_WORKERS; i++) begin
                            if (launch_gnt[i]) wk_prefix[JOB_W*i +: JOB_W] <= JOB_W'(pfx_cnt);
                        end
                    end
                    if (ack_any) begin
                        if (sel_min < MinCost) begin
                            MinCost    <= sel_min;
                            MatchCount <= sel_cnt;
                        end else if (sel_min == MinCost) begin
                            MatchCount <= cnt_sat;
                        end
                    end
                    if (run_done) begin
                        state <= ST_DONE;
                        Valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef JAM_DISPATCH_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cycle_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            cycle_cnt <= '0;
        end else if (state == ST_RUN && cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_jam_dispatch.sv
// Bench for jam_dispatch: behavioural workers, scoreboard of expected merged results per search.
module tb_jam_dispatch;
    import jam_pkg::*;

    localparam int NW = 2;
    localparam int NP = 8;

    logic              CLK;
    logic              RST_N;
    logic              start;
    logic [NW-1:0]     wk_start;
    logic [3*NW-1:0]   wk_prefix;
    logic [NW-1:0]     wk_done;
    logic [10*NW-1:0]  wk_min;
    logic [4*NW-1:0]   wk_count;
    logic [NW-1:0]     wk_ack;
    logic [9:0]        MinCost;
    logic [3:0]        MatchCount;
    logic              Valid;
    logic              busy;
    logic [15:0]       cycle_cnt;

    jam_dispatch #(.NUM_WORKERS(NW), .NUM_PREFIX(NP)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .wk_start   (wk_start),
        .wk_prefix  (wk_prefix),
        .wk_done    (wk_done),
        .wk_min     (wk_min),
        .wk_count   (wk_count),
        .wk_ack     (wk_ack),
        .MinCost    (MinCost),
        .MatchCount (MatchCount),
        .Valid      (Valid),
        .busy       (busy),
        .cycle_cnt  (cycle_cnt)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    logic [13:0] exp_q[$];
    logic [13:0] last_e;

    logic [9:0] res_min[NP];
    logic [3:0] res_cnt[NP];
    logic [2:0] wpfx[NW];
    int         timer[NW];
    bit         wact[NW];
    int         lat_w[NW];
    int         first_ack[NW];
    bit         rand_lat;
    logic [7:0] launched_mask;
    int         launch_cnt;
    int         run_cycles;
    int         valid_total;
    int         cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always_comb begin
        wk_min   = '0;
        wk_count = '0;
        for (int w = 0; w < NW; w++) begin
            wk_min[10*w +: 10] = res_min[wpfx[w]];
            wk_count[4*w +: 4] = res_cnt[wpfx[w]];
        end
    end

    // workers and output monitor, evaluated away from the active edge
    always @(negedge CLK) begin
        logic [13:0] e;
        cyc++;
        if (!RST_N) begin
            wk_done = '0;
            for (int w = 0; w < NW; w++) begin
                wact[w]  = 1'b0;
                timer[w] = 0;
                wpfx[w]  = '0;
            end
        end else begin
            if (wk_ack != '0) check("ack_onehot", 32'($onehot(wk_ack)), 1);
            for (int w = 0; w < NW; w++) begin
                if (wk_ack[w]) begin
                    check($sformatf("pfx_hold%0d", w), 32'(wk_prefix[3*w +: 3]), 32'(wpfx[w]));
                    if (first_ack[w] < 0) first_ack[w] = cyc;
                    wk_done[w] = 1'b0;
                end
                if (wk_start[w]) begin
                    wpfx[w]  = wk_prefix[3*w +: 3];
                    wact[w]  = 1'b1;
                    timer[w] = rand_lat ? int'($urandom_range(1, 12)) : lat_w[w];
                    launched_mask[wpfx[w]] = 1'b1;
                    launch_cnt++;
                end else if (wact[w]) begin
                    timer[w]--;
                    if (timer[w] == 0) begin
                        wact[w]    = 1'b0;
                        wk_done[w] = 1'b1;
                    end
                end
            end
            if (busy && !Valid) run_cycles++;
            if (Valid) begin
                valid_total++;
                check("sb_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    last_e = e;
                    check("min_cost", 32'(MinCost), 32'(e[13:4]));
                    check("match_cnt", 32'(MatchCount), 32'(e[3:0]));
                end
                check("launch_mask", 32'(launched_mask), 32'hFF);
                check("launch_num", 32'(launch_cnt), NP);
`ifdef JAM_DISPATCH_STATS_EN
                check("cycle_cnt", 32'(cycle_cnt), 32'(run_cycles));
`else
                check("cycle_cnt_zero", 32'(cycle_cnt), 0);
`endif
            end
        end
    end

    function automatic logic [13:0] model_result();
        logic [9:0] m;
        int         s;
        m = 10'h3FF;
        for (int k = 0; k < NP; k++) if (res_min[k] < m) m = res_min[k];
        s = 0;
        for (int k = 0; k < NP; k++) if (res_min[k] == m) s += int'(res_cnt[k]);
        if (s > 15) s = 15;
        return {m, 4'(s)};
    endfunction

    // mode 0: k+100 / 1, mode 1: 50 / 3, mode 2: random with frequent ties
    task automatic set_results(input int mode);
        for (int k = 0; k < NP; k++) begin
            case (mode)
                0: begin res_min[k] = 10'(k + 100); res_cnt[k] = 4'd1; end
                1: begin res_min[k] = 10'd50; res_cnt[k] = 4'd3; end
                default: begin
                    res_min[k] = 10'($urandom_range(200, 203));
                    res_cnt[k] = 4'($urandom_range(0, 15));
                end
            endcase
        end
    endtask

    task automatic do_start();
        @(negedge CLK);
        exp_q.push_back(model_result());
        launched_mask = '0;
        launch_cnt    = 0;
        run_cycles    = 0;
        for (int w = 0; w < NW; w++) first_ack[w] = -1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int v0;
        int n;
        v0 = valid_total;
        n  = 0;
        while (valid_total == v0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("valid_seen", 32'(valid_total != v0), 1);
    endtask

    task automatic idle_hold();
        repeat (3) @(negedge CLK);
        check("busy_idle", 32'(busy), 0);
        check("min_hold", 32'(MinCost), 32'(last_e[13:4]));
        check("cnt_hold", 32'(MatchCount), 32'(last_e[3:0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_min"}, 32'(MinCost), 32'h3FF);
        check({tag, "_cnt"}, 32'(MatchCount), 0);
        check({tag, "_valid"}, 32'(Valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_wkstart"}, 32'(wk_start), 0);
        check({tag, "_wkack"}, 32'(wk_ack), 0);
        check({tag, "_wkpfx"}, 32'(wk_prefix), 0);
        check({tag, "_cyc"}, 32'(cycle_cnt), 0);
    endtask

    initial begin
        int v0;
        int n;
        RST_N = 1'b0;
        start = 1'b0;
        wk_done = '0;
        rand_lat = 1'b0;
        valid_total = 0;
        cyc = 0;
        launched_mask = '0;
        launch_cnt = 0;
        run_cycles = 0;
        last_e = '0;
        for (int w = 0; w < NW; w++) begin
            lat_w[w] = 10;
            first_ack[w] = -1;
            wpfx[w] = '0;
            wact[w] = 1'b0;
            timer[w] = 0;
        end
        set_results(0);
        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // ascending costs, single best
        set_results(0);
        do_start();
        check("busy_run", 32'(busy), 1);
        wait_valid(500);
        idle_hold();

        // all ties, tie count saturates
        set_results(1);
        do_start();
        wait_valid(500);
        idle_hold();

        // both workers finish together: worker 0 acked first
        lat_w[0] = 11;
        lat_w[1] = 10;
        set_results(2);
        do_start();
        wait_valid(500);
        check("ack_order", 32'(first_ack[1]), 32'(first_ack[0] + 1));
        lat_w[0] = 10;
        idle_hold();

        // start during RUN is ignored
        set_results(0);
        v0 = valid_total;
        do_start();
        repeat (4) @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("busy_ignored_start", 32'(busy), 1);
        wait_valid(500);
        repeat (20) @(negedge CLK);
        check("one_valid", 32'(valid_total), 32'(v0 + 1));

        // random latencies and results
        rand_lat = 1'b1;
        for (int t = 0; t < 3; t++) begin
            set_results(2);
            do_start();
            wait_valid(800);
            idle_hold();
        end
        rand_lat = 1'b0;

        // reset in the middle of a search
        set_results(2);
        do_start();
        n = 0;
        while (launch_cnt < 3 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("three_launches", 32'(launch_cnt >= 3), 1);
        RST_N = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        set_results(0);
        do_start();
        wait_valid(500);
        idle_hold();

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
